// File: rtl/atm_session_driver_if.sv
// Host-side command/response bus of atm_session_driver.
// The host drives the master modport; the driver sits on the slave modport.
interface atm_session_driver_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_card;
   logic [15:0] cmd_pin;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_amount;
   logic [15:0] cmd_new_pin;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_code;
   logic [15:0] rsp_balance;
   logic [7:0]  rsp_error;

   modport master (
      output cmd_valid, cmd_card, cmd_pin, cmd_op, cmd_amount, cmd_new_pin, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_code, rsp_balance, rsp_error
   );

   modport slave (
      input  cmd_valid, cmd_card, cmd_pin, cmd_op, cmd_amount, cmd_new_pin, rsp_ready,
      output cmd_ready, rsp_valid, rsp_code, rsp_balance, rsp_error
   );
endinterface

// File: rtl/atm_session_driver.sv
// Replays one host command as a card/PIN/request/done session on the ATM core.
// Define ATM_SESSION_STATS_EN to add saturating stat_ok/stat_fail counters.
module atm_session_driver #(
   parameter int unsigned SETTLE_CYC  = 2,
   parameter int unsigned TIMEOUT_CYC = 64,
   parameter logic [7:0]  AUTH_STATE  = 8'h02,
   parameter logic [7:0]  LOCK_STATE  = 8'h05
) (
   input  logic                   clk,
   input  logic                   rst_n,
   atm_session_driver_if.slave    host,
   input  logic [7:0]             atm_state,
   input  logic [15:0]            atm_balance,
   input  logic                   atm_success,
   input  logic [7:0]             atm_error,
   output logic                   card_inserted,
   output logic [7:0]             card_number_input,
   output logic [15:0]            pin_input,
   output logic                   balance_req,
   output logic                   withdrawal_req,
   output logic                   deposit_req,
   output logic                   pin_change_req,
   output logic [15:0]            amount,
   output logic                   transaction_done,
   output logic                   busy
`ifdef ATM_SESSION_STATS_EN
   ,
   output logic [15:0]            stat_ok,
   output logic [15:0]            stat_fail
`endif
);

   localparam int unsigned TMO_W       = $clog2(TIMEOUT_CYC + 1);
   localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);

   typedef enum logic [2:0] {
      S_IDLE, S_INSERT, S_PIN, S_REQ, S_WAIT, S_DONE, S_EJECT, S_RESP
   } state_e;

   typedef enum logic [1:0] {
      RSP_OK        = 2'd0,
      RSP_REJECTED  = 2'd1,
      RSP_AUTH_FAIL = 2'd2,
      RSP_TIMEOUT   = 2'd3
   } rsp_code_e;

   typedef struct packed {
      logic [7:0]  card;
      logic [15:0] pin;
      logic [1:0]  op;
      logic [15:0] amount;
      logic [15:0] new_pin;
   } cmd_t;

   state_e           state_q, state_d;
   cmd_t             cmd_q, cmd_d;
   logic [3:0]       settle_q, settle_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   rsp_code_e        code_q, code_d;
   logic [15:0]      rsp_bal_q, rsp_bal_d;
   logic [7:0]       rsp_err_q, rsp_err_d;

   logic             card_ins_q, card_ins_d;
   logic [7:0]       card_num_q, card_num_d;
   logic [15:0]      pin_q, pin_d;
   logic             bal_req_q, bal_req_d;
   logic             wd_req_q, wd_req_d;
   logic             dep_req_q, dep_req_d;
   logic             pc_req_q, pc_req_d;
   logic [15:0]      amount_q, amount_d;
   logic             done_q, done_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             busy_q, busy_d;

`ifdef ATM_SESSION_STATS_EN
   logic [15:0]      stat_ok_q, stat_ok_d;
   logic [15:0]      stat_fail_q, stat_fail_d;
`endif

   logic accept;
   logic timeout;
   logic rsp_hs;

   assign accept  = host.cmd_valid && cmd_ready_q;
   assign timeout = (tmo_q == TMO_LAST);
   assign rsp_hs  = (state_q == S_RESP) && host.rsp_ready;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d   = state_q;
      cmd_d     = cmd_q;
      settle_d  = settle_q;
      tmo_d     = '0;
      code_d    = code_q;
      rsp_bal_d = rsp_bal_q;
      rsp_err_d = rsp_err_q;

      // The counter only runs while waiting, so it reads zero on entry to PIN and WAIT.
      if (state_q == S_PIN || state_q == S_WAIT) begin
         tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               cmd_d     = '{card:    host.cmd_card,
                             pin:     host.cmd_pin,
                             op:      host.cmd_op,
                             amount:  host.cmd_amount,
                             new_pin: host.cmd_new_pin};
               settle_d  = '0;
               code_d    = RSP_OK;
               rsp_bal_d = '0;
               rsp_err_d = '0;
               state_d   = S_INSERT;
            end
         end
         S_INSERT: begin
            if (settle_q == SETTLE_LAST) state_d = S_PIN;
            else                         settle_d = settle_q + 4'd1;
         end
         S_PIN: begin
            if (atm_state == LOCK_STATE || atm_error != 8'h00) begin
               code_d    = RSP_AUTH_FAIL;
               rsp_bal_d = atm_balance;
               rsp_err_d = atm_error;
               state_d   = S_EJECT;
            end else if (atm_state == AUTH_STATE) begin
               state_d = S_REQ;
            end else if (timeout) begin
               code_d    = RSP_TIMEOUT;
               rsp_bal_d = atm_balance;
               rsp_err_d = atm_error;
               state_d   = S_EJECT;
            end
         end
         S_REQ: state_d = S_WAIT;
         S_WAIT: begin
            if (atm_success || atm_error != 8'h00 || timeout) begin
               // Success wins over a simultaneous error.
               if (atm_success)              code_d = RSP_OK;
               else if (atm_error != 8'h00)  code_d = RSP_REJECTED;
               else                          code_d = RSP_TIMEOUT;
               rsp_bal_d = atm_balance;
               rsp_err_d = atm_error;
               state_d   = S_DONE;
            end
         end
         S_DONE:  state_d = S_EJECT;
         S_EJECT: state_d = S_RESP;
         S_RESP:  if (host.rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they are registered yet aligned with it.
      card_ins_d  = state_d inside {S_INSERT, S_PIN, S_REQ, S_WAIT, S_DONE};
      card_num_d  = card_ins_d ? cmd_d.card : 8'h00;
      pin_d       = 16'h0000;
      if (state_d == S_PIN) begin
         pin_d = cmd_d.pin;
      end else if (state_d inside {S_REQ, S_WAIT, S_DONE}) begin
         pin_d = (cmd_d.op == 2'd3) ? cmd_d.new_pin : cmd_d.pin;
      end
      amount_d    = (state_d inside {S_REQ, S_WAIT, S_DONE}) ? cmd_d.amount : 16'h0000;
      bal_req_d   = (state_d == S_REQ) && (cmd_d.op == 2'd0);
      wd_req_d    = (state_d == S_REQ) && (cmd_d.op == 2'd1);
      dep_req_d   = (state_d == S_REQ) && (cmd_d.op == 2'd2);
      pc_req_d    = (state_d == S_REQ) && (cmd_d.op == 2'd3);
      done_d      = (state_d == S_DONE);
      rsp_valid_d = (state_d == S_RESP);
      cmd_ready_d = (state_d == S_IDLE);
      busy_d      = (state_d != S_IDLE);

`ifdef ATM_SESSION_STATS_EN
      stat_ok_d   = stat_ok_q;
      stat_fail_d = stat_fail_q;
      if (rsp_hs) begin
         if (code_q == RSP_OK) begin
            if (stat_ok_q != 16'hFFFF) stat_ok_d = stat_ok_q + 16'd1;
         end else begin
            if (stat_fail_q != 16'hFFFF) stat_fail_d = stat_fail_q + 16'd1;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: every register is reset so the core sees a card-out, request-free bus immediately.
         state_q     <= S_IDLE;
         cmd_q       <= '0;
         settle_q    <= '0;
         tmo_q       <= '0;
         code_q      <= RSP_OK;
         rsp_bal_q   <= '0;
         rsp_err_q   <= '0;
         card_ins_q  <= 1'b0;
         card_num_q  <= '0;
         pin_q       <= '0;
         bal_req_q   <= 1'b0;
         wd_req_q    <= 1'b0;
         dep_req_q   <= 1'b0;
         pc_req_q    <= 1'b0;
         amount_q    <= '0;
         done_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         cmd_ready_q <= 1'b1;
         busy_q      <= 1'b0;
`ifdef ATM_SESSION_STATS_EN
         stat_ok_q   <= '0;
         stat_fail_q <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q     <= state_d;
         cmd_q       <= cmd_d;
         settle_q    <= settle_d;
         tmo_q       <= tmo_d;
         code_q      <= code_d;
         rsp_bal_q   <= rsp_bal_d;
         rsp_err_q   <= rsp_err_d;
         card_ins_q  <= card_ins_d;
         card_num_q  <= card_num_d;
         pin_q       <= pin_d;
         bal_req_q   <= bal_req_d;
         wd_req_q    <= wd_req_d;
         dep_req_q   <= dep_req_d;
         pc_req_q    <= pc_req_d;
         amount_q    <= amount_d;
         done_q      <= done_d;
         rsp_valid_q <= rsp_valid_d;
         cmd_ready_q <= cmd_ready_d;
         busy_q      <= busy_d;
`ifdef ATM_SESSION_STATS_EN
         stat_ok_q   <= stat_ok_d;
         stat_fail_q <= stat_fail_d;
`endif
      end
   end

   assign card_inserted     = card_ins_q;
   assign card_number_input = card_num_q;
   assign pin_input         = pin_q;
   assign balance_req       = bal_req_q;
   assign withdrawal_req    = wd_req_q;
   assign deposit_req       = dep_req_q;
   assign pin_change_req    = pc_req_q;
   assign amount            = amount_q;
   assign transaction_done  = done_q;
   assign busy              = busy_q;

   assign host.cmd_ready    = cmd_ready_q;
   assign host.rsp_valid    = rsp_valid_q;
   assign host.rsp_code     = code_q;
   assign host.rsp_balance  = rsp_bal_q;
   assign host.rsp_error    = rsp_err_q;

`ifdef ATM_SESSION_STATS_EN
   assign stat_ok   = stat_ok_q;
   assign stat_fail = stat_fail_q;
`endif

endmodule

// File: doc/atm_session_driver.md
Name: atm_session_driver

Overview:
- Initiator-side sequencer that drives the atm_module customer interface on behalf of a host.
- Accepts one complete transaction command per valid/ready handshake (card, PIN, operation, amount).
- Replays it as the card/PIN/request/transaction_done sequence the ATM core expects, monitors the core's state/success/error outputs, then ejects the card.
- Returns a single response word to the host. Sits between a host/test controller (or front-panel logic) and atm_module.

Parameters:
- SETTLE_CYC, 2, cycles card_inserted and card_number_input are held before the PIN is presented (1..15).
- TIMEOUT_CYC, 64, maximum cycles waited in any WAIT state before abort (2..65535).
- AUTH_STATE, 8'h02, atm_state value meaning "authenticated, menu ready".
- LOCK_STATE, 8'h05, atm_state value meaning "card locked".

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  driver can accept a command
- cmd_card  in  8  card number
- cmd_pin  in  16  PIN
- cmd_op  in  2  operation: 0 balance, 1 withdrawal, 2 deposit, 3 PIN change
- cmd_amount  in  16  amount for withdrawal/deposit
- cmd_new_pin  in  16  new PIN for op 3
- atm_state  in  8  ATM core current_state
- atm_balance  in  16  ATM core balance
- atm_success  in  1  ATM core transaction_success
- atm_error  in  8  ATM core error_code, 0 = no error
- card_inserted  out  1  to ATM core
- card_number_input  out  8  to ATM core
- pin_input  out  16  to ATM core
- balance_req  out  1  to ATM core
- withdrawal_req  out  1  to ATM core
- deposit_req  out  1  to ATM core
- pin_change_req  out  1  to ATM core
- amount  out  16  to ATM core
- transaction_done  out  1  to ATM core
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_code  out  2  0 OK, 1 REJECTED, 2 AUTH_FAIL, 3 TIMEOUT
- rsp_balance  out  16  atm_balance sampled at completion
- rsp_error  out  8  atm_error sampled at completion
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State to IDLE; all outputs 0 except cmd_ready=1.
  - Command registers and timeout counter cleared.
  - Reset mid-session drops card_inserted immediately (asynchronously).
- Handshake and capture:
  - Command captured on the clk edge where cmd_valid && cmd_ready; cmd_ready=1 only in IDLE.
  - All fields are registered; later changes on cmd_* are ignored.
- FSM states and transitions:
  - IDLE: on accept, go to INSERT.
  - INSERT: card_inserted=1, card_number_input=cmd_card. After SETTLE_CYC cycles, go to PIN.
  - PIN: pin_input=cmd_pin, held. Exits, in priority order:
    - atm_state==LOCK_STATE or atm_error!=0: code AUTH_FAIL, go to EJECT.
    - atm_state==AUTH_STATE: go to REQ.
    - Timeout: code TIMEOUT, go to EJECT.
  - REQ: exactly one request line pulses for exactly one cycle, selected by cmd_op.
    - amount=cmd_amount, driven from REQ through DONE.
    - For op 3, pin_input switches to cmd_new_pin in the REQ cycle.
    - Always go to WAIT.
  - WAIT: exits, in priority order:
    - atm_success=1: code OK.
    - atm_error!=0: code REJECTED.
    - Timeout: code TIMEOUT.
    - On exit, sample atm_balance/atm_error into rsp regs and go to DONE.
  - DONE: transaction_done=1 for one cycle, then go to EJECT. Skipped for AUTH_FAIL and TIMEOUT-from-PIN.
  - EJECT: card_inserted=0, pin_input=0, amount=0 for one cycle, then go to RESP.
  - RESP: rsp_valid=1 with stable rsp_code/rsp_balance/rsp_error until rsp_ready. On the handshake cycle, go to IDLE.
- Timeout counter:
  - Cleared on entry to PIN and to WAIT; increments each cycle in those states.
  - Timeout fires when the count reaches TIMEOUT_CYC-1, i.e. the exit occurs on the TIMEOUT_CYC-th cycle in that state.
  - Width is $clog2(TIMEOUT_CYC+1); the counter never wraps.
- Simultaneous events: success and error in the same WAIT cycle resolve as OK.
- Invariant: never more than one *_req line high at once.
- Latency, best case OK: accept → rsp_valid = SETTLE_CYC + 1 (PIN) + 1 (REQ) + 1 (WAIT) + 1 (DONE) + 1 (EJECT) cycles.

Optional Feature:
- Macro ATM_SESSION_STATS_EN.
- When defined:
  - Adds outputs stat_ok [15:0] and stat_fail [15:0]. Both are saturating counters, cleared by reset.
  - stat_ok increments on the RESP handshake when rsp_code=OK.
  - stat_fail increments on the RESP handshake for any other code.
- When undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Balance, correct PIN: cmd card 8'h00, pin 16'h1234, op 0, ATM model reaches AUTH_STATE then success → single balance_req pulse, one transaction_done pulse, rsp_code=0, rsp_balance = model balance.
- Wrong PIN: card 8'h01, pin 16'h1111, model raises error_code 8'h01 → no *_req pulse, no transaction_done, rsp_code=2, rsp_error=8'h01, card_inserted low in EJECT.
- Over-withdrawal: op 1, amount 16'hFFFF, model sets error 8'h03 → rsp_code=1, rsp_error=8'h03; then op 1, amount 16'h0050 → rsp_code=0 and balance reduced by 16'h0050.
- Timeout: model holds atm_state at 8'h00 → rsp_code=3 exactly TIMEOUT_CYC cycles after PIN entry; card_inserted returns to 0.
- Reset mid-WAIT: rst_n low during op 2 → card_inserted, all *_req and rsp_valid go to 0 asynchronously; cmd_ready=1 after release.
- Backpressure: hold rsp_ready=0 for 10 cycles → rsp_valid and rsp fields stable, cmd_ready stays 0; with ATM_SESSION_STATS_EN defined, stat_ok increments once, on the handshake cycle only.
